// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data-port load/store requests.
//   Accepts one request at a time over a valid/ready request channel,
//   waits WAIT_CYCLES extra cycles, then performs the word read or the
//   byte-masked write. The result goes back over a valid/ready response
//   channel. Used to exercise multi-cycle memory timing.
//
// Parameters
//   ADDR_W       request byte-address width
//   DEPTH        RAM size in 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (registered)
//   req_we     1 = store, 0 = load
//   req_addr   byte address; word index = req_addr[ADDR_W-1:2]
//   req_wdata  store data
//   req_be     store byte enables; bit i -> bits [8i+7:8i]
//   rsp_valid  response present (registered)
//   rsp_ready  requester takes response
//   rsp_rdata  load data, 0 for stores and errors (registered)
//   rsp_err    request rejected (registered)
//
// Build option
//   DMEM_ERR_CHECK_EN  when defined, misaligned or out-of-range requests
//                      return rsp_err=1 without touching the RAM. When
//                      undefined, rsp_err is always 0, req_addr[1:0] is
//                      ignored and the word index wraps modulo DEPTH.

module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic             req_ready_n, rsp_valid_n, rsp_err_n;
  logic [31:0]      rsp_rdata_n;
  logic             capture;
  logic             mem_wr;
  logic             req_err;

  logic             cap_we;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_be;
  logic [IDX_W-1:0] cap_idx;

  logic [31:0]      mem [DEPTH];

`ifdef DMEM_ERR_CHECK_EN
  logic             cap_misaligned;
  logic             cap_out_of_range;
  logic [ADDR_W-3:0] req_word;

  assign req_word = req_addr[ADDR_W-1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_misaligned   <= 1'b0;
      cap_out_of_range <= 1'b0;
    end else if (capture) begin
      cap_misaligned   <= (req_addr[1:0] != 2'b00);
      cap_out_of_range <= ((req_word >> IDX_W) != '0);
    end
  end

  assign req_err = cap_misaligned | cap_out_of_range;
`else
  logic addr_unused;
  assign addr_unused = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
  assign req_err     = 1'b0;
`endif

  // Request capture; only these registered copies are used after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_we    <= 1'b0;
      cap_wdata <= '0;
      cap_be    <= '0;
      cap_idx   <= '0;
    end else if (capture) begin
      cap_we    <= req_we;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
      cap_idx   <= req_addr[IDX_W+1:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

  // The counter is loaded with WAIT_CYCLES (not WAIT_CYCLES-1) because the
  // accept edge moves to WAIT rather than RESP; this yields the response on
  // edge T+1+WAIT_CYCLES, including the WAIT_CYCLES=0 case.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    req_ready_n = req_ready;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    capture     = 1'b0;
    mem_wr      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid && req_ready) begin
          capture     = 1'b1;
          req_ready_n = 1'b0;
          cnt_n       = 4'(WAIT_CYCLES);
          state_n     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = req_err;
          if (req_err || cap_we) begin
            rsp_rdata_n = '0;
            mem_wr      = cap_we & ~req_err;
          end else begin
            rsp_rdata_n = mem[cap_idx];
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b0;
          req_ready_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // RAM is not reset. During reset the FSM sits in IDLE, so mem_wr is low
  // and an abandoned store never lands.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (cap_be[b]) begin
          mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference memory: plain word arrays, one per instance.
  logic [31:0] ref_mem [2][256];

  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=2; instance 1: WAIT_CYCLES=0.
  dmem_responder #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Full transaction on instance d; assumes entry at a negedge, leaves at one.
  task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, input bit hold_req);
    int unsigned wait_cycles;
    logic [29:0] widx;
    logic [7:0]  idx;
    bit          err;
    logic [31:0] exp_rd;
    int          k;
    int          lat;

    wait_cycles = (d == 0) ? 2 : 0;
    widx = addr[31:2];
    idx  = widx[7:0];
`ifdef DMEM_ERR_CHECK_EN
    err = (addr[1:0] != 2'b00) || (widx >= 30'd256);
`else
    err = 1'b0;
`endif
    exp_rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = ref_mem[d][idx];
      end
    end

    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", {31'b0, req_ready[d]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("req_ready_after_accept", {31'b0, req_ready[d]}, 32'd0);

    lat = 0;
    while (!rsp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 1 + wait_cycles);
    check("rsp_err", {31'b0, rsp_err[d]}, {31'b0, err});
    check("rsp_rdata", rsp_rdata[d], exp_rd);
    check("no_ready_with_valid", {31'b0, req_ready[d]}, 32'd0);

    for (int h = 0; h < hold; h++) begin
      if (hold_req) req_valid[d] = 1'b1;
      @(negedge clk);
      check("hold_rsp_valid", {31'b0, rsp_valid[d]}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata[d], exp_rd);
      check("hold_req_ready", {31'b0, req_ready[d]}, 32'd0);
    end

    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    check("post_hs_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
    check("post_hs_rsp_rdata", rsp_rdata[d], 32'h0);
    check("post_hs_req_ready", {31'b0, req_ready[d]}, 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", {31'b0, req_ready[d]}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata[d], 32'h0);
      check("rst_rsp_err", {31'b0, rsp_err[d]}, 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_req_ready_low", {31'b0, req_ready[0]}, 32'd0);
    @(negedge clk);
    check("rel_req_ready_high0", {31'b0, req_ready[0]}, 32'd1);
    check("rel_req_ready_high1", {31'b0, req_ready[1]}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_be[d] = '0;   rsp_ready[d] = 1'b0;
    end
    @(negedge clk);
    apply_reset();

    // Fill both RAMs so every later load has a defined expectation.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        do_txn(d, 1'b1, i * 4, $urandom, 4'hF, 0, 1'b0);

    // Directed: full store/load, single-byte store.
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    do_txn(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 0, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    check("byte_merge_model", ref_mem[0][4], 32'hDEADABEF);

    // Backpressure with a second request waiting.
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1);
    do_txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0);

    // be=0 store is a no-op; load ignores be.
    do_txn(0, 1'b1, 32'h10, 32'h11111111, 4'h0, 1, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h5, 0, 1'b0);

    // Range / alignment cases (expected outcome depends on build option).
    do_txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 0, 1'b0);
    do_txn(0, 1'b1, 32'h13, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

    // WAIT_CYCLES=0 back-to-back with immediate response acceptance.
    for (int i = 0; i < 6; i++)
      do_txn(1, i[0], 32'(i * 4), 32'hA5A50000 + 32'(i), 4'hF, 0, 1'b0);

    // Reset in the middle of a store's wait period.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    apply_reset();
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      int d;
      d = int'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) a = $urandom;
      else a = {22'b0, 8'($urandom), 2'b00};
      do_txn(d, 1'($urandom), a, $urandom, 4'($urandom),
             int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
